// File: rtl/scroll_ctrl.sv
// Multiplexed 8-digit scrolling message controller: digit scan, scroll FSM and address generation.
// Optional STOP-mode blinking is compiled in when SCROLL_BLINK_EN is defined.
module scroll_ctrl #(
  parameter int unsigned SCAN_DIV      = 100000,
  parameter int unsigned SCROLL_FRAMES = 64,
  parameter int unsigned BLINK_FRAMES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] SW,
  output logic [7:0] AN,
  output logic [3:0] addr,
  output logic       frame_end
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = $clog2(SCROLL_FRAMES + 1);

  localparam logic [1:0] StStop  = 2'd0;
  localparam logic [1:0] StRight = 2'd1;
  localparam logic [1:0] StLeft  = 2'd2;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [3:0]    offset_q, offset_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    addr_q, addr_d;
  logic          fe_q, fe_d;
  logic          scan_tick;
  logic          wrap;
  logic [1:0]    req;
  logic [FW-1:0] limit;

  assign scan_tick = (presc_q == PW'(SCAN_DIV - 1));
  assign wrap      = scan_tick && (digit_q == 3'd7);

  always_comb begin
    presc_d = scan_tick ? '0 : presc_q + PW'(1);
    digit_d = scan_tick ? digit_q + 3'd1 : digit_q;
  end

  // Mode and offset only move on the 7->0 wrap, so a whole frame uses one offset.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    fcnt_d   = fcnt_q;
    limit    = SW[2] ? FW'(SCROLL_FRAMES / 2) : FW'(SCROLL_FRAMES);
    case (SW[1:0])
      2'b01:   req = StRight;
      2'b10:   req = StLeft;
      2'b11:   req = StStop;
      default: req = state_q;
    endcase
    if (wrap) begin
      if (req != state_q) begin
        state_d = req;
        fcnt_d  = '0;
      end else if (state_q != StStop) begin
        // >= rather than == so a drop to the fast limit steps on the next frame.
        if (fcnt_q >= limit - FW'(1)) begin
          fcnt_d   = '0;
          offset_d = (state_q == StRight) ? offset_q - 4'd1 : offset_q + 4'd1;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
    end
  end

  always_comb begin
    an_d   = an_q;
    addr_d = addr_q;
    fe_d   = 1'b0;
    if (scan_tick) begin
      an_d   = ~(8'd1 << digit_d);
      addr_d = {1'b0, digit_d} + offset_d;
      fe_d   = wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      digit_q  <= '0;
      offset_q <= '0;
      fcnt_q   <= '0;
      state_q  <= StStop;
      an_q     <= 8'hFE;
      addr_q   <= '0;
      fe_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      offset_q <= offset_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      an_q     <= an_d;
      addr_q   <= addr_d;
      fe_q     <= fe_d;
    end
  end

  assign addr      = addr_q;
  assign frame_end = fe_q;

`ifdef SCROLL_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (state_d != StStop) begin
        bcnt_d  = '0;
        phase_d = 1'b0;
      end else if (state_q == StStop) begin
        if (bcnt_q >= BW'(BLINK_FRAMES - 1)) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign AN = phase_q ? 8'hFF : an_q;
`else
  assign AN = an_q;
`endif

endmodule

// File: tb/tb_scroll_ctrl.sv
// Scoreboard bench for scroll_ctrl with SCAN_DIV=4, SCROLL_FRAMES=4, BLINK_FRAMES=1.
module tb_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] SW  = 3'b000;
  logic [7:0] AN;
  logic [3:0] addr;
  logic       frame_end;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] addr;
    logic       fe;
  } exp_t;

  exp_t sb[$];

  scroll_ctrl #(
    .SCAN_DIV     (4),
    .SCROLL_FRAMES(4),
    .BLINK_FRAMES (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SW       (SW),
    .AN       (AN),
    .addr     (addr),
    .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  // Expected AN given the plain scan value and the STOP blink phase.
  function automatic logic [7:0] blank(input logic [7:0] scan, input bit ph);
`ifdef SCROLL_BLINK_EN
    return ph ? 8'hFF : scan;
`else
    return (ph && 1'b0) ? 8'hFF : scan;
`endif
  endfunction

  task automatic do_reset(input logic [2:0] sw);
    @(negedge clk);
    rst = 1'b1;
    SW  = sw;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_frame(output bit got);
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (frame_end === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    exp_t       e;
    logic [7:0] scan;
    int         dg;
    do_reset(3'b000);
    total++;
    if ({AN, addr, frame_end} !== {8'hFE, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got AN=%h addr=%h fe=%b want AN=fe addr=0 fe=0",
               AN, addr, frame_end);
    end
    for (int k = 1; k <= 40; k++) begin
      dg   = (k / 4) % 8;
      scan = ~(8'd1 << dg);
      sb.push_back('{an: blank(scan, ((k / 32) % 2) == 1), addr: 4'(dg),
                     fe: (k % 32) == 0});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({AN, addr, frame_end} !== {e.an, e.addr, e.fe}) begin
        bad++;
        $display("FAIL scan_walk k=%0d: got AN=%h addr=%h fe=%b want AN=%h addr=%h fe=%b",
                 k, AN, addr, frame_end, e.an, e.addr, e.fe);
      end
    end
  endtask

  task automatic test_right;
    exp_t e;
    bit   got;
    do_reset(3'b001);
    for (int f = 1; f <= 9; f++) begin
      sb.push_back('{an: 8'hFE, addr: (f < 5) ? 4'd0 : (f < 9) ? 4'd15 : 4'd14, fe: 1'b1});
      wait_frame(got);
      e = sb.pop_front();
      total++;
      if (!got) begin
        bad++;
        $display("FAIL right_frame%0d: got no frame_end want frame_end", f);
      end else if ({AN, addr} !== {e.an, e.addr}) begin
        bad++;
        $display("FAIL right_frame%0d: got AN=%h addr=%h want AN=%h addr=%h",
                 f, AN, addr, e.an, e.addr);
      end
    end
    repeat (4) @(negedge clk);
    total++;
    if ({AN, addr} !== {8'hFD, 4'd15}) begin
      bad++;
      $display("FAIL right_digit1: got AN=%h addr=%h want AN=fd addr=f", AN, addr);
    end
    repeat (4) @(negedge clk);
    total++;
    if ({AN, addr} !== {8'hFB, 4'd0}) begin
      bad++;
      $display("FAIL right_digit2_wrap: got AN=%h addr=%h want AN=fb addr=0", AN, addr);
    end
  endtask

  task automatic test_left;
    exp_t e;
    bit   got;
    do_reset(3'b010);
    for (int f = 1; f <= 65; f++) begin
      sb.push_back('{an: 8'hFE, addr: 4'(((f - 1) / 4) % 16), fe: 1'b1});
      wait_frame(got);
      e = sb.pop_front();
      total++;
      if (!got) begin
        bad++;
        $display("FAIL left_frame%0d: got no frame_end want frame_end", f);
      end else if ({AN, addr} !== {e.an, e.addr}) begin
        bad++;
        $display("FAIL left_frame%0d: got AN=%h addr=%h want AN=%h addr=%h",
                 f, AN, addr, e.an, e.addr);
      end
    end
  endtask

  task automatic test_fast;
    exp_t       e;
    bit         got;
    logic [3:0] tbl [12];
    tbl = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    do_reset(3'b110);
    for (int f = 1; f <= 12; f++) begin
      sb.push_back('{an: 8'hFE, addr: tbl[f-1], fe: 1'b1});
      wait_frame(got);
      e = sb.pop_front();
      total++;
      if (!got) begin
        bad++;
        $display("FAIL fast_frame%0d: got no frame_end want frame_end", f);
      end else if ({AN, addr} !== {e.an, e.addr}) begin
        bad++;
        $display("FAIL fast_frame%0d: got AN=%h addr=%h want AN=%h addr=%h",
                 f, AN, addr, e.an, e.addr);
      end
      if (f == 6) SW = 3'b010;
      if (f == 11) SW = 3'b110;
    end
  endtask

  task automatic test_stop;
    exp_t e;
    bit   got;
    do_reset(3'b001);
    for (int f = 1; f <= 10; f++) begin
      sb.push_back('{an: blank(8'hFE, (f >= 6) && ((f - 6) % 2 == 1)),
                     addr: (f < 5) ? 4'd0 : 4'd15, fe: 1'b1});
      wait_frame(got);
      e = sb.pop_front();
      total++;
      if (!got) begin
        bad++;
        $display("FAIL stop_frame%0d: got no frame_end want frame_end", f);
      end else if ({AN, addr} !== {e.an, e.addr}) begin
        bad++;
        $display("FAIL stop_frame%0d: got AN=%h addr=%h want AN=%h addr=%h",
                 f, AN, addr, e.an, e.addr);
      end
      if (f == 5) begin
        repeat (16) @(negedge clk);
        SW = 3'b011;
        total++;
        if ({AN, addr} !== {8'hEF, 4'd3}) begin
          bad++;
          $display("FAIL stop_midframe: got AN=%h addr=%h want AN=ef addr=3", AN, addr);
        end
      end
      if (f == 6) SW = 3'b000;
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   got;
    do_reset(3'b010);
    for (int f = 1; f <= 21; f++) begin
      wait_frame(got);
      if (f == 21) begin
        total++;
        if (!got || addr !== 4'd5) begin
          bad++;
          $display("FAIL midrst_setup: got addr=%h fe_seen=%b want addr=5 fe_seen=1", addr, got);
        end
      end
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    SW  = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({AN, addr, frame_end} !== {8'hFE, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_state: got AN=%h addr=%h fe=%b want AN=fe addr=0 fe=0",
               AN, addr, frame_end);
    end
    for (int f = 1; f <= 3; f++) begin
      sb.push_back('{an: blank(8'hFE, (f % 2) == 1), addr: 4'd0, fe: 1'b1});
      wait_frame(got);
      e = sb.pop_front();
      total++;
      if (!got) begin
        bad++;
        $display("FAIL midrst_frame%0d: got no frame_end want frame_end", f);
      end else if ({AN, addr} !== {e.an, e.addr}) begin
        bad++;
        $display("FAIL midrst_frame%0d: got AN=%h addr=%h want AN=%h addr=%h",
                 f, AN, addr, e.an, e.addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_right();
    test_left();
    test_fast();
    test_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
